// File: rtl/output_part.sv
// Transmit side of the slot-load protocol. It captures four sorted words in a
// single cycle and replays them one word per valid/ready handshake on a one-hot slot select.
module output_part #(
  parameter int DATA_W = 4,
  parameter bit ORDER  = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [DATA_W-1:0] sorted_num0,
  input  logic [DATA_W-1:0] sorted_num1,
  input  logic [DATA_W-1:0] sorted_num2,
  input  logic [DATA_W-1:0] sorted_num3,
  output logic [3:0]        out_sel,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    DONE = 2'd2
  } state_t;

  // ORDER picks the direction in which the slot index walks.
  localparam logic [1:0] FIRST_IDX = ORDER ? 2'd3 : 2'd0;
  localparam logic [1:0] LAST_IDX  = ORDER ? 2'd0 : 2'd3;

  state_t                  state_q, state_d;
  logic [3:0][DATA_W-1:0]  wbuf_q, wbuf_d;
  logic [1:0]              idx_q, idx_d;
  logic [1:0]              idx_nxt;
  logic [3:0]              sel_q, sel_d;
  logic [DATA_W-1:0]       data_q, data_d;
  logic                    valid_q, valid_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic [3:0][DATA_W-1:0]  in_word;

  assign in_word = {sorted_num3, sorted_num2, sorted_num1, sorted_num0};
  assign idx_nxt = ORDER ? (idx_q - 2'd1) : (idx_q + 2'd1);

  function automatic logic [3:0] onehot(input logic [1:0] i);
    onehot = 4'b0001 << i;
  endfunction

  always_comb begin
    state_d = state_q;
    wbuf_d  = wbuf_q;
    idx_d   = idx_q;
    sel_d   = sel_q;
    data_d  = data_q;
    valid_d = valid_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        sel_d   = 4'b0000;
        data_d  = '0;
        valid_d = 1'b0;
        busy_d  = 1'b0;
        if (load) begin
          // The first word comes straight from the inputs, so it is valid in the cycle after load.
          wbuf_d  = in_word;
          idx_d   = FIRST_IDX;
          sel_d   = onehot(FIRST_IDX);
          data_d  = in_word[FIRST_IDX];
          valid_d = 1'b1;
          busy_d  = 1'b1;
          state_d = SEND;
        end
      end
      SEND: begin
        if (valid_q && out_ready) begin
          if (idx_q == LAST_IDX) begin
            sel_d   = 4'b0000;
            data_d  = '0;
            valid_d = 1'b0;
            done_d  = 1'b1;
            state_d = DONE;
          end else begin
            idx_d  = idx_nxt;
            sel_d  = onehot(idx_nxt);
            data_d = wbuf_q[idx_nxt];
          end
        end
      end
      DONE: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: begin
        sel_d   = 4'b0000;
        data_d  = '0;
        valid_d = 1'b0;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      wbuf_q  <= '0;
      idx_q   <= 2'd0;
      sel_q   <= 4'b0000;
      data_q  <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      wbuf_q  <= wbuf_d;
      idx_q   <= idx_d;
      sel_q   <= sel_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign out_sel   = sel_q;
  assign out_data  = data_q;
  assign out_valid = valid_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_output_part.sv
// Bench for output_part: an ascending and a descending instance run on shared stimulus
// and are checked against a transaction-level queue model.
module tb_output_part;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       load;
  logic       out_ready;
  logic [3:0] n0, n1, n2, n3;

  logic [3:0] sel0, sel1, data0, data1;
  logic       v0, v1, b0, b1, dn0, dn1;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  output_part #(.DATA_W(4), .ORDER(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n), .load(load),
    .sorted_num0(n0), .sorted_num1(n1), .sorted_num2(n2), .sorted_num3(n3),
    .out_sel(sel0), .out_data(data0), .out_valid(v0), .out_ready(out_ready),
    .busy(b0), .done(dn0)
  );

  output_part #(.DATA_W(4), .ORDER(1'b1)) dut1 (
    .clk(clk), .rst_n(rst_n), .load(load),
    .sorted_num0(n0), .sorted_num1(n1), .sorted_num2(n2), .sorted_num3(n3),
    .out_sel(sel1), .out_data(data1), .out_valid(v1), .out_ready(out_ready),
    .busy(b1), .done(dn1)
  );

  logic [10:0] obs0, obs1;
  assign obs0 = {v0, sel0, data0, b0, dn0};
  assign obs1 = {v1, sel1, data1, b1, dn1};

  // Reference: a captured block is a list of slot indices still to be sent.
  bit [3:0] cap [4];
  int       qa[$];
  int       qd[$];
  bit       done_m;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      qa.delete();
      qd.delete();
      done_m = 1'b0;
      for (int i = 0; i < 4; i++) cap[i] = 4'd0;
    end else if (done_m) begin
      done_m = 1'b0;
    end else if (qa.size() > 0) begin
      if (out_ready) begin
        void'(qa.pop_front());
        void'(qd.pop_front());
        if (qa.size() == 0) done_m = 1'b1;
      end
    end else if (load) begin
      cap[0] = n0; cap[1] = n1; cap[2] = n2; cap[3] = n3;
      for (int i = 0; i < 4; i++) begin
        qa.push_back(i);
        qd.push_back(3 - i);
      end
    end
  end

  function automatic logic [10:0] exp_vec(input bit desc);
    bit         v;
    int         slot;
    logic [3:0] s;
    logic [3:0] d;
    v    = (qa.size() > 0);
    slot = v ? (desc ? qd[0] : qa[0]) : 0;
    s    = v ? (4'b0001 << slot) : 4'b0000;
    d    = v ? cap[slot] : 4'd0;
    return {v, s, d, v | done_m, done_m};
  endfunction

  // Loopback receiver: slot registers written on each handshake.
  logic [3:0] lb0 [4];
  logic [3:0] lb1 [4];
  always @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (v0 && out_ready && sel0[i]) lb0[i] <= data0;
      if (v1 && out_ready && sel1[i]) lb1[i] <= data1;
    end
  end

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_data(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c, input logic [3:0] d);
    n0 = a; n1 = b; n2 = c; n3 = d;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; load = 1'b0; out_ready = 1'b0;
    set_data(4'd5, 4'd6, 4'd7, 4'd8);
    #1;
    vectors++;
    if (obs0 !== 11'd0) begin miscompares++; $display("FAIL reset_asc obs=%b exp=%b", obs0, 11'd0); end
    vectors++;
    if (obs1 !== 11'd0) begin miscompares++; $display("FAIL reset_desc obs=%b exp=%b", obs1, 11'd0); end
    tick(); tick();
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      out_ready = 1'($urandom_range(0, 1));
      tick();
      vectors++;
      if (obs0 !== exp_vec(0)) begin miscompares++; $display("FAIL idle_asc c=%0d obs=%b exp=%b", c, obs0, exp_vec(0)); end
      vectors++;
      if (obs1 !== exp_vec(1)) begin miscompares++; $display("FAIL idle_desc c=%0d obs=%b exp=%b", c, obs1, exp_vec(1)); end
    end
  endtask

  task automatic test_stream;
    logic [3:0] sa [6];
    logic [3:0] sd [6];
    logic [3:0] da [6];
    logic [3:0] dd [6];
    logic [10:0] e0, e1;
    sa = '{4'd1, 4'd2, 4'd4, 4'd8, 4'd0, 4'd0};
    sd = '{4'd8, 4'd4, 4'd2, 4'd1, 4'd0, 4'd0};
    da = '{4'd1, 4'd3, 4'd7, 4'd9, 4'd0, 4'd0};
    dd = '{4'd9, 4'd7, 4'd3, 4'd1, 4'd0, 4'd0};
    set_data(4'd1, 4'd3, 4'd7, 4'd9);
    load = 1'b1; out_ready = 1'b1;
    tick();
    load = 1'b0;
    set_data(4'd0, 4'd0, 4'd0, 4'd0);
    for (int c = 0; c < 6; c++) begin
      e0 = {1'(c < 4), sa[c], da[c], 1'(c < 5), 1'(c == 4)};
      e1 = {1'(c < 4), sd[c], dd[c], 1'(c < 5), 1'(c == 4)};
      vectors++;
      if (obs0 !== e0) begin miscompares++; $display("FAIL stream_asc_cycle N+%0d obs=%b exp=%b", c + 1, obs0, e0); end
      vectors++;
      if (obs1 !== e1) begin miscompares++; $display("FAIL stream_desc_cycle N+%0d obs=%b exp=%b", c + 1, obs1, e1); end
      vectors++;
      if (obs0 !== exp_vec(0)) begin miscompares++; $display("FAIL stream_model_asc c=%0d obs=%b exp=%b", c, obs0, exp_vec(0)); end
      tick();
    end
  endtask

  task automatic test_backpressure;
    bit         r [10];
    logic [3:0] got[$];
    int         held;
    r = '{1, 0, 0, 0, 1, 1, 1, 1, 1, 1};
    held = 0;
    set_data(4'd1, 4'd3, 4'd7, 4'd9);
    load = 1'b1; out_ready = 1'b1;
    tick();
    load = 1'b0;
    for (int c = 0; c < 10; c++) begin
      out_ready = r[c];
      #1;
      if (v0 && out_ready) got.push_back(data0);
      if (sel0 == 4'b0010 && data0 == 4'd3) held++;
      vectors++;
      if (obs0 !== exp_vec(0)) begin miscompares++; $display("FAIL bp_asc c=%0d obs=%b exp=%b", c, obs0, exp_vec(0)); end
      vectors++;
      if (obs1 !== exp_vec(1)) begin miscompares++; $display("FAIL bp_desc c=%0d obs=%b exp=%b", c, obs1, exp_vec(1)); end
      tick();
    end
    vectors++;
    if (held !== 4) begin miscompares++; $display("FAIL bp_hold_cycles got=%0d exp=4", held); end
    vectors++;
    if (got.size() !== 4 || got[0] !== 4'd1 || got[1] !== 4'd3 || got[2] !== 4'd7 || got[3] !== 4'd9) begin
      miscompares++; $display("FAIL bp_sequence got=%p exp=1,3,7,9", got);
    end
  endtask

  task automatic test_load_ignored;
    bit         ld [8];
    logic [3:0] got[$];
    ld = '{0, 1, 1, 0, 1, 0, 0, 0};
    set_data(4'd2, 4'd4, 4'd6, 4'd8);
    load = 1'b1; out_ready = 1'b1;
    tick();
    set_data(4'd15, 4'd15, 4'd15, 4'd15);
    for (int c = 0; c < 8; c++) begin
      load = ld[c];
      if (v1) got.push_back(data1);
      vectors++;
      if (obs0 !== exp_vec(0)) begin miscompares++; $display("FAIL ldign_asc c=%0d obs=%b exp=%b", c, obs0, exp_vec(0)); end
      vectors++;
      if (obs1 !== exp_vec(1)) begin miscompares++; $display("FAIL ldign_desc c=%0d obs=%b exp=%b", c, obs1, exp_vec(1)); end
      tick();
    end
    load = 1'b0;
    vectors++;
    if (got.size() !== 4 || got[0] !== 4'd8 || got[1] !== 4'd6 || got[2] !== 4'd4 || got[3] !== 4'd2) begin
      miscompares++; $display("FAIL ldign_sequence got=%p exp=8,6,4,2", got);
    end
  endtask

  task automatic test_load_held;
    int restart;
    restart = -1;
    set_data(4'd1, 4'd2, 4'd3, 4'd4);
    load = 1'b1; out_ready = 1'b1;
    tick();
    set_data(4'd11, 4'd12, 4'd13, 4'd14);
    for (int c = 1; c < 14; c++) begin
      if (c > 4 && v0 && restart < 0) restart = c;
      vectors++;
      if (obs0 !== exp_vec(0)) begin miscompares++; $display("FAIL held_asc c=%0d obs=%b exp=%b", c, obs0, exp_vec(0)); end
      vectors++;
      if (obs1 !== exp_vec(1)) begin miscompares++; $display("FAIL held_desc c=%0d obs=%b exp=%b", c, obs1, exp_vec(1)); end
      tick();
    end
    load = 1'b0;
    vectors++;
    if (restart !== 7) begin miscompares++; $display("FAIL held_restart_cycle got=N+%0d exp=N+7", restart); end
    for (int c = 0; c < 10; c++) tick();
  endtask

  task automatic test_reset_mid;
    set_data(4'd9, 4'd8, 4'd7, 4'd6);
    load = 1'b1; out_ready = 1'b1;
    tick();
    load = 1'b0;
    tick(); tick();
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    if (obs0 !== 11'd0) begin miscompares++; $display("FAIL midreset_asc obs=%b exp=%b", obs0, 11'd0); end
    vectors++;
    if (obs1 !== 11'd0) begin miscompares++; $display("FAIL midreset_desc obs=%b exp=%b", obs1, 11'd0); end
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      tick();
      vectors++;
      if (obs0 !== exp_vec(0)) begin miscompares++; $display("FAIL postreset_asc c=%0d obs=%b exp=%b", c, obs0, exp_vec(0)); end
      vectors++;
      if (obs1 !== exp_vec(1)) begin miscompares++; $display("FAIL postreset_desc c=%0d obs=%b exp=%b", c, obs1, exp_vec(1)); end
    end
  endtask

  task automatic test_random;
    for (int c = 0; c < 400; c++) begin
      load      = ($urandom_range(0, 2) == 0);
      out_ready = 1'($urandom_range(0, 1));
      set_data(4'($urandom), 4'($urandom), 4'($urandom), 4'($urandom));
      tick();
      vectors++;
      if (obs0 !== exp_vec(0)) begin miscompares++; $display("FAIL rand_asc c=%0d obs=%b exp=%b", c, obs0, exp_vec(0)); end
      vectors++;
      if (obs1 !== exp_vec(1)) begin miscompares++; $display("FAIL rand_desc c=%0d obs=%b exp=%b", c, obs1, exp_vec(1)); end
    end
    load = 1'b0; out_ready = 1'b1;
    for (int c = 0; c < 8; c++) tick();
  endtask

  task automatic test_loopback;
    logic [3:0] w [4];
    bit         seen;
    seen = 1'b0;
    for (int i = 0; i < 4; i++) w[i] = 4'($urandom);
    set_data(w[0], w[1], w[2], w[3]);
    load = 1'b1; out_ready = 1'b1;
    tick();
    load = 1'b0;
    set_data(4'd0, 4'd0, 4'd0, 4'd0);
    for (int c = 0; c < 20 && !seen; c++) begin
      if (dn0 && dn1) seen = 1'b1;
      else tick();
    end
    vectors++;
    if (!seen) begin miscompares++; $display("FAIL loopback_done_timeout got=0 exp=1"); end
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if (lb0[i] !== w[i] || lb1[i] !== w[i]) begin
        miscompares++; $display("FAIL loopback_slot%0d asc=%h desc=%h exp=%h", i, lb0[i], lb1[i], w[i]);
      end
    end
    tick(); tick();
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_load_ignored();
    test_load_held();
    test_reset_mid();
    test_random();
    test_loopback();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/output_part.md
Name: output_part

Overview:
- Transmit side of the slot-load protocol used by the sorter's input stage.
- Captures four sorted DATA_W-bit results in one cycle.
- Replays them one word per handshake on a one-hot slot select (0001/0010/0100/1000), a data bus and a strobe.
- Sits after the sorter core and drives the display/downstream stage, or feeds the input stage directly for loopback testing.

Parameters:
- DATA_W, 4, width of each number and of out_data.
- ORDER, 0, 0 = send slot0 first (ascending slot index); 1 = send slot3 first (descending slot index).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- load  input  1  capture request; honoured only in IDLE.
- sorted_num0  input  DATA_W  result for slot 0.
- sorted_num1  input  DATA_W  result for slot 1.
- sorted_num2  input  DATA_W  result for slot 2.
- sorted_num3  input  DATA_W  result for slot 3.
- out_sel  output  4  one-hot slot select; 0000 when idle.
- out_data  output  DATA_W  word for the selected slot.
- out_valid  output  1  strobe; word is offered while high.
- out_ready  input  1  downstream accepts the word when high together with out_valid.
- busy  output  1  high in SEND and DONE.
- done  output  1  one-cycle pulse after the last word is accepted.

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low on rst_n.
- Reset (rst_n=0, any time, including mid-transfer): all outputs go to 0, the capture buffer is cleared, the slot index is cleared, state is IDLE. Operation resumes on the first clk edge after rst_n deassertion.
- All outputs are registered.
- State machine: IDLE -> SEND -> DONE -> IDLE.
- IDLE:
  - out_valid=0, out_sel=0000, out_data=0, busy=0, done=0.
  - On an edge with load=1: capture sorted_num0..3 into the buffer, set index to 0 (ORDER=0) or 3 (ORDER=1), go to SEND.
  - In that same edge, out_valid=1, out_sel=one-hot(index), out_data=buffer[index]. The first word is therefore valid in the cycle after load.
- SEND:
  - Handshake occurs on an edge where out_valid=1 and out_ready=1.
  - Without a handshake, out_sel and out_data hold stable; this holds for any number of stall cycles.
  - On a handshake that is not the last word: advance the index by +1 (ORDER=0) or -1 (ORDER=1). The next word is presented on that same edge, so back-to-back transfers run at one word per cycle.
  - On the handshake of the 4th word: go to DONE; out_valid=0, out_sel=0000, out_data=0, done=1.
- DONE: done=1 for exactly one cycle, busy=1, then go to IDLE.
- load while in SEND or DONE is ignored; sorted_num inputs may change freely after capture without effect.
- load held high continuously: a new capture occurs on the first IDLE edge, so the steady-state period is 6 cycles per block with out_ready=1.
- out_ready while out_valid=0 has no effect.
- Minimum latency with out_ready tied high:
  - load sampled at edge N;
  - words present in cycles N+1..N+4;
  - done in cycle N+5;
  - IDLE in cycle N+6.
- out_sel is always one-hot or zero; never multi-hot.

Test Plan:
- Reset/idle: assert rst_n=0 mid-SEND (after 2 words) -> outputs immediately 0, state IDLE. After release, no output activity until load.
- Streaming: ORDER=0, inputs 1,3,7,9, load pulse, out_ready=1 -> out_sel/out_data = 0001/1, 0010/3, 0100/7, 1000/9 in cycles N+1..N+4; done=1 only in cycle N+5; busy high N+1..N+5.
- Backpressure: same data, out_ready=0 for 3 cycles during word 2 -> out_sel=0010, out_data=3 held stable for 4 cycles; no word skipped or duplicated; done one cycle after word 4.
- Reverse order: ORDER=1, inputs 2,4,6,8 -> sequence 1000/8, 0100/6, 0010/4, 0001/2.
- Load ignored: pulse load with new data 15,15,15,15 during SEND and during DONE -> original words transmitted unchanged, no restart. load held high -> second block starts at cycle N+6 with the new inputs.
- Loopback: connect out_sel/out_data/out_valid to the input stage's select/data/enable with out_ready=1 -> the input stage's four registers equal the captured values after done.
